mem_writeback_stage: RTL and testbench
======================================

# mem_writeback_stage

Memory-and-writeback end of the processor pipeline: consumes the M-stage bundle (RD1M, ALUResultM, WA3M, WA4M, RegWriteAM, RegWriteBM, MemtoRegM) produced by the E→M pipeline register. It performs the data-memory access and registers the results into the W stage. It drives the register file's two write ports (A and B) and keeps a count of retired instructions. Sits between the E→M register and the register file / hazard unit.

## Interface
Parameters:
- DEPTH, 256, data-memory words (8-bit each); addressed by ALUResultM[log2(DEPTH)-1:0]

Ports:
- clk  in  1  pipeline clock, rising-edge
- reset  in  1  asynchronous, active-high
- RD1M  in  8  store data / port-B write data
- ALUResultM  in  8  ALU result / memory address
- WA3M  in  3  port-A destination register
- WA4M  in  3  port-B destination register
- RegWriteAM  in  1  port-A write enable
- RegWriteBM  in  1  port-B write enable
- MemtoRegM  in  1  port-A data selects memory read over ALU result
- MemWriteM  in  1  store strobe
- ValidM  in  1  M slot holds a real instruction (0 = bubble)
- StallW  in  1  hold W registers, suppress store
- FlushW  in  1  kill M instruction (becomes bubble in W)
- WD3W  out  8  port-A write data
- WA3W  out  3  port-A address
- RegWriteAW  out  1  port-A enable
- WD4W  out  8  port-B write data
- WA4W  out  3  port-B address
- RegWriteBW  out  1  port-B enable
- RetiredW  out  8  retired-instruction counter

## Operation
- Memory read: combinational in M: ReadDataM = mem[ALUResultM]. Write: synchronous at rising edge when MemWriteM & ValidM & ~StallW & ~FlushW.
- Port-A data: MemtoRegM ? ReadDataM : ALUResultM. Port-B data: RD1M.
- Write collision: if RegWriteAM & RegWriteBM & (WA3M == WA4M), port A wins; RegWriteBW is registered as 0.
- Advance (~StallW, ~FlushW): all W registers load M-stage values. RegWrite*W are gated by ValidM.
- Flush (FlushW=1, wins over StallW): RegWriteAW=RegWriteBW=0, the store is suppressed, and the data/address registers load don't-care (implementation loads M values).
- Stall (StallW=1, FlushW=0): all W registers and RetiredW hold. No memory write occurs.
- RetiredW: increments at a clock edge when a valid instruction advances into W (ValidM & ~StallW & ~FlushW). Wraps 255→0.
- Reset (asynchronous, any time including mid-stall): WD3W, WD4W, WA3W, WA4W, RegWriteAW, RegWriteBW and RetiredW all clear to 0. Memory contents are not reset. No store occurs while reset is high.

## Timing
- Latency: an instruction in M during cycle n presents W outputs in cycle n+1, one edge later.
- A store in M at cycle n updates memory at the end of cycle n. A load of the same address in M at cycle n+1 returns the new data.
- Outputs are pure registers. There is no combinational path from M inputs to W outputs.
- During a stall, the M inputs are expected to be held upstream. When the stall releases, the store executes exactly once.
- Reset deassertion: normal operation from the first subsequent rising edge.

## Test plan
- Reset mid-stream: assert reset with RegWriteAW=1 and RetiredW=0x05 → all outputs read 0 immediately without waiting for a clock edge. After release, RetiredW counts from 0.
- Store then load: store RD1M=0xA5 to addr 0x10, then next cycle load addr 0x10 (MemtoRegM=1, WA3M=2, RegWriteAM=1) → WD3W=0xA5, WA3W=2, RegWriteAW=1 one cycle after the load.
- Dual write with collision: WA3M=WA4M=5, both enables=1, ALUResultM=0x33, RD1M=0x44 → next cycle RegWriteAW=1, WD3W=0x33, RegWriteBW=0. Repeat with WA4M=6 → RegWriteBW=1, WD4W=0x44.
- Stall/flush: a store to addr 0x20 with FlushW=1 → mem[0x20] unchanged and RegWrite*W=0. A store with StallW=1 for 3 cycles then released → exactly one write, and W outputs hold during the stall.
- Counter wrap: 256 valid advances from reset → RetiredW returns to 0x00. Bubbles (ValidM=0) do not increment.

Source files
------------

// File: rtl/mem_writeback_stage_if.sv
// mem_writeback_stage_if
// Bundles the M-stage instruction fields entering the memory/writeback stage
// and the registered W-stage register-file write ports leaving it.
//   M side : RD1M, ALUResultM, WA3M, WA4M, RegWriteAM, RegWriteBM, MemtoRegM,
//            MemWriteM, ValidM, plus the W-stage controls StallW and FlushW
//   W side : WD3W/WA3W/RegWriteAW (write port A), WD4W/WA4W/RegWriteBW
//            (write port B), RetiredW (retired-instruction count)
// master = the upstream pipeline / register file side, slave = the stage.
interface mem_writeback_stage_if;
  logic [7:0] RD1M;
  logic [7:0] ALUResultM;
  logic [2:0] WA3M;
  logic [2:0] WA4M;
  logic       RegWriteAM;
  logic       RegWriteBM;
  logic       MemtoRegM;
  logic       MemWriteM;
  logic       ValidM;
  logic       StallW;
  logic       FlushW;

  logic [7:0] WD3W;
  logic [2:0] WA3W;
  logic       RegWriteAW;
  logic [7:0] WD4W;
  logic [2:0] WA4W;
  logic       RegWriteBW;
  logic [7:0] RetiredW;

  modport master (
    output RD1M, ALUResultM, WA3M, WA4M, RegWriteAM, RegWriteBM, MemtoRegM,
           MemWriteM, ValidM, StallW, FlushW,
    input  WD3W, WA3W, RegWriteAW, WD4W, WA4W, RegWriteBW, RetiredW
  );

  modport slave (
    input  RD1M, ALUResultM, WA3M, WA4M, RegWriteAM, RegWriteBM, MemtoRegM,
           MemWriteM, ValidM, StallW, FlushW,
    output WD3W, WA3W, RegWriteAW, WD4W, WA4W, RegWriteBW, RetiredW
  );
endinterface

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage
// Memory-access and writeback end of the pipeline. Performs the data-memory
// read/write for the instruction in M and registers its results into W, where
// they drive the two register-file write ports. Also counts retired
// instructions.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; clears all W registers and the counter
//   bus   : mem_writeback_stage_if.slave (M-stage inputs, W-stage outputs)
// Parameter:
//   DEPTH : number of 8-bit data-memory words, addressed by the low
//           log2(DEPTH) bits of ALUResultM
module mem_writeback_stage #(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_writeback_stage_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The load result is needed in the same M cycle, so the memory is read
  // asynchronously (distributed RAM) rather than through a registered port.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] mem_addr;
  logic [7:0]    read_data;

  logic          advance;
  logic          store_en;
  logic          b_enable;
  logic [7:0]    a_data;

  logic [7:0]    wd3_reg;
  logic [2:0]    wa3_reg;
  logic          rwa_reg;
  logic [7:0]    wd4_reg;
  logic [2:0]    wa4_reg;
  logic          rwb_reg;
  logic [7:0]    retired_reg;

  assign mem_addr  = bus.ALUResultM[AW-1:0];
  assign read_data = mem[mem_addr];

  // Flush overrides stall; only an unstalled, unflushed slot moves into W.
  assign advance   = ~bus.StallW & ~bus.FlushW;

  // Reset is included so no store can slip through while reset is held.
  assign store_en  = bus.MemWriteM & bus.ValidM & advance & ~reset;

  assign a_data    = bus.MemtoRegM ? read_data : bus.ALUResultM;

  // Both ports targeting the same register: port A takes it, port B drops.
  assign b_enable  = bus.RegWriteBM &
                     ~(bus.RegWriteAM & (bus.WA3M == bus.WA4M));

  // Data memory: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[mem_addr] <= bus.RD1M;
    end
  end

  // W-stage pipeline register and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd3_reg     <= 8'd0;
      wa3_reg     <= 3'd0;
      rwa_reg     <= 1'b0;
      wd4_reg     <= 8'd0;
      wa4_reg     <= 3'd0;
      rwb_reg     <= 1'b0;
      retired_reg <= 8'd0;
    end else if (bus.FlushW) begin
      // Data/address contents are don't-care on flush; loading the M values
      // keeps the datapath enables simple. Only the write enables matter.
      wd3_reg <= a_data;
      wa3_reg <= bus.WA3M;
      rwa_reg <= 1'b0;
      wd4_reg <= bus.RD1M;
      wa4_reg <= bus.WA4M;
      rwb_reg <= 1'b0;
    end else if (advance) begin
      wd3_reg <= a_data;
      wa3_reg <= bus.WA3M;
      rwa_reg <= bus.ValidM & bus.RegWriteAM;
      wd4_reg <= bus.RD1M;
      wa4_reg <= bus.WA4M;
      rwb_reg <= bus.ValidM & b_enable;
      if (bus.ValidM) begin
        retired_reg <= retired_reg + 8'd1;
      end
    end
  end

  assign bus.WD3W       = wd3_reg;
  assign bus.WA3W       = wa3_reg;
  assign bus.RegWriteAW = rwa_reg;
  assign bus.WD4W       = wd4_reg;
  assign bus.WA4W       = wa4_reg;
  assign bus.RegWriteBW = rwb_reg;
  assign bus.RetiredW   = retired_reg;
endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage
// Drives the memory/writeback stage with directed scenarios and random
// instruction streams. A behavioural model tracks the data memory as a plain
// array and the expected W outputs; a compare process checks every cycle on
// the falling edge, and directed steps pin key results to literal values.
module tb_mem_writeback_stage;
  logic clk;
  logic reset;

  mem_writeback_stage_if bus ();

  mem_writeback_stage #(.DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0] model_mem [256];
  logic [7:0] e_wd3, e_wd4, e_ret;
  logic [2:0] e_wa3, e_wa4;
  logic       e_rwa, e_rwb;
  bit         e_dc;   // data/address registers are don't-care (after flush)

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_wd3 = 0; e_wa3 = 0; e_rwa = 0;
      e_wd4 = 0; e_wa4 = 0; e_rwb = 0;
      e_ret = 0; e_dc = 0;
    end else if (bus.FlushW) begin
      e_rwa = 0; e_rwb = 0; e_dc = 1;
    end else if (!bus.StallW) begin
      e_dc  = 0;
      e_wd3 = bus.MemtoRegM ? model_mem[bus.ALUResultM] : bus.ALUResultM;
      e_wa3 = bus.WA3M;
      e_wd4 = bus.RD1M;
      e_wa4 = bus.WA4M;
      e_rwa = bus.ValidM && bus.RegWriteAM;
      e_rwb = bus.ValidM && bus.RegWriteBM &&
              !(bus.RegWriteAM && bus.WA3M == bus.WA4M);
      if (bus.ValidM) begin
        e_ret = e_ret + 8'd1;
        if (bus.MemWriteM) model_mem[bus.ALUResultM] = bus.RD1M;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("RegWriteAW", {31'd0, bus.RegWriteAW}, {31'd0, e_rwa});
      chk("RegWriteBW", {31'd0, bus.RegWriteBW}, {31'd0, e_rwb});
      chk("RetiredW",   {24'd0, bus.RetiredW},   {24'd0, e_ret});
      if (!e_dc) begin
        chk("WD3W", {24'd0, bus.WD3W}, {24'd0, e_wd3});
        chk("WA3W", {29'd0, bus.WA3W}, {29'd0, e_wa3});
        chk("WD4W", {24'd0, bus.WD4W}, {24'd0, e_wd4});
        chk("WA4W", {29'd0, bus.WA4W}, {29'd0, e_wa4});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input logic v, input logic mw, input logic m2r,
                       input logic [7:0] alu, input logic [7:0] rd1,
                       input logic rwa, input logic [2:0] wa3,
                       input logic rwb, input logic [2:0] wa4,
                       input logic st, input logic fl);
    bus.ValidM = v;  bus.MemWriteM = mw; bus.MemtoRegM = m2r;
    bus.ALUResultM = alu; bus.RD1M = rd1;
    bus.RegWriteAM = rwa; bus.WA3M = wa3;
    bus.RegWriteBM = rwb; bus.WA4M = wa4;
    bus.StallW = st; bus.FlushW = fl;
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic step(input string tag);
    $display("txn %s: v=%0b mw=%0b m2r=%0b alu=%02h rd1=%02h a=%0b/%0d b=%0b/%0d st=%0b fl=%0b",
             tag, bus.ValidM, bus.MemWriteM, bus.MemtoRegM, bus.ALUResultM, bus.RD1M,
             bus.RegWriteAM, bus.WA3M, bus.RegWriteBM, bus.WA4M, bus.StallW, bus.FlushW);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] held_ret;

  initial begin
    reset = 1'b0;
    set_m(0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 3'd0, 0, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_RetiredW", {24'd0, bus.RetiredW}, 32'd0);
    chk("reset_RegWriteAW", {31'd0, bus.RegWriteAW}, 32'd0);
    reset = 1'b0;

    // Preload every memory word; also 256 valid advances wrap the counter.
    for (int i = 0; i < 256; i++) begin
      set_m(1, 1, 0, 8'(i), 8'($urandom), 0, 3'd0, 0, 3'd0, 0, 0);
      step("preload");
      if (i == 254) chk("ret_255", {24'd0, bus.RetiredW}, 32'hFF);
      if (i == 255) chk("ret_wrap", {24'd0, bus.RetiredW}, 32'h00);
    end

    // Bubbles (even carrying a store strobe) neither count nor write.
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1, 0, 8'h40, 8'hEE, 1, 3'd1, 1, 3'd2, 0, 0);
      step("bubble");
    end
    chk("bubble_ret", {24'd0, bus.RetiredW}, 32'h00);
    chk("bubble_rwa", {31'd0, bus.RegWriteAW}, 32'd0);
    set_m(1, 0, 1, 8'h40, 8'h00, 1, 3'd1, 0, 3'd0, 0, 0);
    step("load40");

    // Store then load same address.
    set_m(1, 1, 0, 8'h10, 8'hA5, 0, 3'd0, 0, 3'd0, 0, 0);
    step("store10");
    set_m(1, 0, 1, 8'h10, 8'h00, 1, 3'd2, 0, 3'd0, 0, 0);
    step("load10");
    chk("ld_WD3W", {24'd0, bus.WD3W}, 32'hA5);
    chk("ld_WA3W", {29'd0, bus.WA3W}, 32'd2);
    chk("ld_RegWriteAW", {31'd0, bus.RegWriteAW}, 32'd1);

    // Dual write, collision then distinct destinations.
    set_m(1, 0, 0, 8'h33, 8'h44, 1, 3'd5, 1, 3'd5, 0, 0);
    step("collide");
    chk("col_RegWriteAW", {31'd0, bus.RegWriteAW}, 32'd1);
    chk("col_WD3W", {24'd0, bus.WD3W}, 32'h33);
    chk("col_RegWriteBW", {31'd0, bus.RegWriteBW}, 32'd0);
    set_m(1, 0, 0, 8'h33, 8'h44, 1, 3'd5, 1, 3'd6, 0, 0);
    step("dual");
    chk("dual_RegWriteBW", {31'd0, bus.RegWriteBW}, 32'd1);
    chk("dual_WD4W", {24'd0, bus.WD4W}, 32'h44);

    // Flushed store must not reach memory.
    set_m(1, 1, 0, 8'h20, 8'h11, 0, 3'd0, 0, 3'd0, 0, 0);
    step("store20");
    set_m(1, 1, 0, 8'h20, 8'h99, 1, 3'd1, 1, 3'd2, 0, 1);
    step("flush_store20");
    chk("fl_RegWriteAW", {31'd0, bus.RegWriteAW}, 32'd0);
    chk("fl_RegWriteBW", {31'd0, bus.RegWriteBW}, 32'd0);
    set_m(1, 0, 1, 8'h20, 8'h00, 1, 3'd3, 0, 3'd0, 0, 0);
    step("load20");
    chk("fl_mem20", {24'd0, bus.WD3W}, 32'h11);

    // Stall for 3 cycles on a store, then release.
    set_m(1, 0, 0, 8'h55, 8'h00, 1, 3'd3, 0, 3'd0, 0, 0);
    step("alu55");
    chk("pre_stall_WD3W", {24'd0, bus.WD3W}, 32'h55);
    held_ret = bus.RetiredW;
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 0, 8'h30, 8'h77, 1, 3'd4, 0, 3'd0, 1, 0);
      step("stall_store30");
      chk("stall_WD3W", {24'd0, bus.WD3W}, 32'h55);
      chk("stall_WA3W", {29'd0, bus.WA3W}, 32'd3);
      chk("stall_ret", {24'd0, bus.RetiredW}, {24'd0, held_ret});
    end
    set_m(1, 1, 0, 8'h30, 8'h77, 1, 3'd4, 0, 3'd0, 0, 0);
    step("release_store30");
    chk("rel_WD3W", {24'd0, bus.WD3W}, 32'h30);
    chk("rel_ret", {24'd0, bus.RetiredW}, {24'd0, held_ret + 8'd1});
    set_m(1, 0, 1, 8'h30, 8'h00, 1, 3'd4, 0, 3'd0, 0, 0);
    step("load30");
    chk("rel_mem30", {24'd0, bus.WD3W}, 32'h77);

    // Random instruction stream.
    for (int i = 0; i < 1000; i++) begin
      set_m($urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom),
            8'($urandom),
            $urandom_range(0, 1) == 1, 3'($urandom),
            $urandom_range(0, 1) == 1, 3'($urandom),
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 1);
      step("rand");
    end

    // Reset mid-stream with live outputs.
    set_m(0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 3'd0, 0, 0);
    step("idle");
    reset = 1'b1;
    step("reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_m(1, 0, 0, 8'(8'h60 + i), 8'h00, 1, 3'd1, 0, 3'd0, 0, 0);
      step("count");
    end
    chk("pre_rst_ret", {24'd0, bus.RetiredW}, 32'h05);
    chk("pre_rst_rwa", {31'd0, bus.RegWriteAW}, 32'd1);
    set_m(1, 1, 0, 8'h10, 8'h5A, 1, 3'd1, 1, 3'd2, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_RetiredW", {24'd0, bus.RetiredW}, 32'd0);
    chk("async_RegWriteAW", {31'd0, bus.RegWriteAW}, 32'd0);
    chk("async_RegWriteBW", {31'd0, bus.RegWriteBW}, 32'd0);
    chk("async_WD3W", {24'd0, bus.WD3W}, 32'd0);
    chk("async_WA3W", {29'd0, bus.WA3W}, 32'd0);
    chk("async_WD4W", {24'd0, bus.WD4W}, 32'd0);
    chk("async_WA4W", {29'd0, bus.WA4W}, 32'd0);
    step("reset_held");
    reset = 1'b0;
    set_m(1, 0, 1, 8'h10, 8'h00, 1, 3'd2, 0, 3'd0, 0, 0);
    step("post_rst_load10");
    chk("post_rst_ret", {24'd0, bus.RetiredW}, 32'h01);
    chk("no_store_in_reset", {24'd0, bus.WD3W}, 32'hA5);

    set_m(0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 3'd0, 0, 0);
    step("drain");
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
